// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand-conditioning mode codes and the status flag record
// that travels alongside every conditioned operand.
package alu_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_INV  = 2'b01;
  localparam logic [1:0] MODE_NEG  = 2'b10;
  localparam logic [1:0] MODE_ABS  = 2'b11;

  typedef struct packed {
    logic ovf;
    logic zero;
  } status_t;

  // NEG and ABS are the only modes that can add one, so only they can overflow.
  function automatic logic mode_can_negate(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/operand_negate_pipe_if.sv
// Valid/ready bundle for the operand conditioning stage: upstream operand beat in,
// conditioned operand plus flags out.
interface operand_negate_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_mode, out_ready,
    input  in_ready, out_valid, out_y, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_mode, out_ready,
    output in_ready, out_valid, out_y, out_ovf, out_zero
  );
endinterface

// File: rtl/operand_negate_pipe_negate_unit.sv
// Combinational operand conditioner: per-bit NOT + select, followed by a ripple +1
// that turns the inversion into a two's complement negation for NEG/ABS.
module negate_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_a,
  input  logic [1:0]       in_mode,
  output logic [WIDTH-1:0] y,
  output logic             ovf,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             invert;
  logic             increment;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] carry;

  always_comb begin
    invert    = 1'b0;
    increment = 1'b0;
    case (in_mode)
      MODE_PASS: begin invert = 1'b0;             increment = 1'b0;             end
      MODE_INV:  begin invert = 1'b1;             increment = 1'b0;             end
      MODE_NEG:  begin invert = 1'b1;             increment = 1'b1;             end
      default:   begin invert = in_a[WIDTH-1];    increment = in_a[WIDTH-1];    end
    endcase
  end

  assign carry[0] = increment;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
      assign sel[gi] = invert ? ~in_a[gi] : in_a[gi];
      assign y[gi]   = sel[gi] ^ carry[gi];
      // The carry out of the top slice is dropped: the +1 wraps mod 2^WIDTH.
      if (gi < WIDTH - 1) begin : g_carry
        assign carry[gi+1] = sel[gi] & carry[gi];
      end
    end
  endgenerate

  assign ovf  = mode_can_negate(in_mode) & (in_a == MOST_NEG);
  assign zero = ~|y;

endmodule

// File: rtl/operand_negate_pipe.sv
// Registered operand conditioner: negate_unit result captured into a 2-entry FIFO
// whose head drives the output side; absorbs one cycle of downstream backpressure.
module operand_negate_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  operand_negate_pipe_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    status_t          st;
  } result_t;

  result_t          slot [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  logic [WIDTH-1:0] nu_y;
  logic             nu_ovf;
  logic             nu_zero;
  result_t          new_result;
  result_t          head;
  logic             has_data;
  logic             accept;
  logic             deliver;

  negate_unit #(.WIDTH(WIDTH)) u_negate (
    .in_a    (bus.in_a),
    .in_mode (bus.in_mode),
    .y       (nu_y),
    .ovf     (nu_ovf),
    .zero    (nu_zero)
  );

  assign new_result = '{y: nu_y, st: '{ovf: nu_ovf, zero: nu_zero}};

  // in_ready is a pure function of count so it never loops through out_ready.
  assign bus.in_ready = (count != 2'd2);
  assign has_data     = (count != 2'd0);
  assign accept       = bus.in_valid & bus.in_ready;
  assign deliver      = has_data & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        slot[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (accept) begin
        slot[wr_ptr] <= new_result;
        wr_ptr       <= ~wr_ptr;
      end
      if (deliver) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({accept, deliver})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // An empty buffer presents all-zero outputs rather than a stale slot.
  assign head          = has_data ? slot[rd_ptr] : '0;
  assign bus.out_valid = has_data;
  assign bus.out_y     = head.y;
  assign bus.out_ovf   = head.st.ovf;
  assign bus.out_zero  = head.st.zero;

endmodule

// File: tb/tb_operand_negate_pipe.sv
// Randomized scoreboard bench for operand_negate_pipe (WIDTH=8): accepted beats are
// predicted by an arithmetic model; a monitor pops and compares on every delivery.
module tb_operand_negate_pipe;
  import alu_pkg::*;

  typedef struct {
    int y;
    int ovf;
    int zero;
  } exp_t;

  logic clk;
  logic rst;

  operand_negate_pipe_if #(.WIDTH(8)) bus ();

  operand_negate_pipe #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   tests     = 0;
  int   fails     = 0;
  int   timeouts  = 0;
  int   drain_req = 0;

  // Reference: plain integer arithmetic on the operand's numeric value.
  function automatic exp_t ref_model(input logic [7:0] a, input logic [1:0] mode);
    exp_t e;
    int av;
    int sv;
    av = int'(a);
    sv = (av >= 128) ? av - 256 : av;
    case (mode)
      MODE_PASS: e.y = av;
      MODE_INV:  e.y = 255 - av;
      MODE_NEG:  e.y = (256 - av) % 256;
      default:   e.y = (sv < 0) ? ((-sv) % 256) : av;
    endcase
    e.ovf  = ((mode == MODE_NEG || mode == MODE_ABS) && av == 128) ? 1 : 0;
    e.zero = (e.y == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard feed: every handshake on the input side predicts one output.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(ref_model(bus.in_a, bus.in_mode));
    end
  end

  // Monitor: occupancy tracked from observed handshakes, delivery checked against queue.
  int   occ        = 0;
  bit   stall_prev = 1'b0;
  int   prev_y     = 0;
  int   prev_ovf   = 0;
  int   prev_zero  = 0;
  int   drain_seen = 0;
  int   delivered  = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      occ        = 0;
      stall_prev = 1'b0;
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_y",     int'(bus.out_y),     0);
      chk("rst_out_ovf",   int'(bus.out_ovf),   0);
      chk("rst_out_zero",  int'(bus.out_zero),  0);
      chk("rst_in_ready",  int'(bus.in_ready),  1);
    end else begin
      chk("in_ready_vs_occ",  int'(bus.in_ready),  (occ < 2) ? 1 : 0);
      chk("out_valid_vs_occ", int'(bus.out_valid), (occ > 0) ? 1 : 0);
      if (stall_prev) begin
        chk("stall_y",    int'(bus.out_y),    prev_y);
        chk("stall_ovf",  int'(bus.out_ovf),  prev_ovf);
        chk("stall_zero", int'(bus.out_zero), prev_zero);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          delivered++;
          $display("[TB] beat %0d: y=%02h ovf=%0d zero=%0d (exp y=%02h ovf=%0d zero=%0d)",
                   delivered, bus.out_y, bus.out_ovf, bus.out_zero, e.y, e.ovf, e.zero);
          chk("out_y",    int'(bus.out_y),    e.y);
          chk("out_ovf",  int'(bus.out_ovf),  e.ovf);
          chk("out_zero", int'(bus.out_zero), e.zero);
        end
      end
      occ = occ + ((bus.in_valid && bus.in_ready) ? 1 : 0)
                - ((bus.out_valid && bus.out_ready) ? 1 : 0);
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_y     = int'(bus.out_y);
      prev_ovf   = int'(bus.out_ovf);
      prev_zero  = int'(bus.out_zero);
      if (drain_req != drain_seen) begin
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("send_timeouts", timeouts, 0);
        drain_seen = drain_req;
      end
    end
  end

  // Hold a beat until the DUT shows in_ready, bounded so a stuck DUT cannot hang the run.
  task automatic send(input logic [7:0] a, input logic [1:0] mode);
    bit ok;
    ok          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_mode  = mode;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeouts++;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [7:0] rand_operand();
    logic [7:0] a;
    a = 8'($urandom_range(0, 255));
    if ($urandom_range(0, 7) == 0) a = 8'h80;
    if ($urandom_range(0, 9) == 0) a = 8'h00;
    return a;
  endfunction

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'h00;
    bus.in_mode   = MODE_PASS;
    bus.out_ready = 1'b1;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed function cases
    send(8'h05, MODE_NEG);
    send(8'h05, MODE_INV);
    send(8'h80, MODE_NEG);
    send(8'hF6, MODE_ABS);
    send(8'h00, MODE_NEG);
    send(8'h80, MODE_ABS);
    send(8'h00, MODE_PASS);
    send(8'h7F, MODE_ABS);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: two fill the buffer, the third waits for out_ready
    bus.out_ready = 1'b0;
    send(8'd11, MODE_PASS);
    send(8'd22, MODE_PASS);
    fork
      send(8'd33, MODE_PASS);
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Reset while the buffer is full drops everything
    bus.out_ready = 1'b0;
    send(rand_operand(), 2'($urandom_range(0, 3)));
    send(rand_operand(), 2'($urandom_range(0, 3)));
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Continuous stream, no backpressure
    for (int i = 0; i < 16; i++) begin
      send(rand_operand(), 2'($urandom_range(0, 3)));
    end
    repeat (3) @(posedge clk);
    #1;

    // Full buffer with randomly toggling out_ready
    bus.out_ready = 1'b0;
    send(rand_operand(), 2'($urandom_range(0, 3)));
    send(rand_operand(), 2'($urandom_range(0, 3)));
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          send(rand_operand(), 2'($urandom_range(0, 3)));
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(posedge clk);
          #1 bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join

    // Drain and final accounting
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    drain_req++;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
